// File: rtl/mem_dma_pkg.sv
// Shared definitions for the block-copy / block-fill DMA engine:
// FSM state encoding and transfer-mode constants.
package mem_dma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dma_addr_gen.sv
// Source/destination pointers and the remaining-byte counter of the DMA.
// Direction is chosen once at load so overlapping copies behave like memmove.
module dma_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              copy_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] src_ptr_o,
  output logic [ADDR_W-1:0] dst_ptr_o,
  output logic [ADDR_W-1:0] remaining_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              bwd_q, bwd_d;
  logic [ADDR_W-1:0] gap;
  logic              backward;

  // A destination starting inside the source window must be filled from the top down.
  assign gap      = dst_base_i - src_base_i;
  assign backward = copy_i && (dst_base_i != src_base_i) && (gap < len_i);

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    bwd_d = bwd_q;
    if (load_i) begin
      bwd_d = backward;
      rem_d = len_i;
      if (backward) begin
        src_d = src_base_i + len_i - ONE;
        dst_d = dst_base_i + len_i - ONE;
      end else begin
        src_d = src_base_i;
        dst_d = dst_base_i;
      end
    end else if (step_i) begin
      rem_d = rem_q - ONE;
      if (bwd_q) begin
        src_d = src_q - ONE;
        dst_d = dst_q - ONE;
      end else begin
        src_d = src_q + ONE;
        dst_d = dst_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      bwd_q <= 1'b0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      bwd_q <= bwd_d;
    end
  end

  assign src_ptr_o   = src_q;
  assign dst_ptr_o   = dst_q;
  assign remaining_o = rem_q;
  assign last_o      = (rem_q == ONE);

endmodule

// File: rtl/mem_copy_dma.sv
// Memory-to-memory DMA initiator: memmove-style COPY or constant FILL over a
// byte-wide data memory port, one access per cycle.
module mem_copy_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] remaining,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              load;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;

  assign load = (state_q == ST_IDLE) && start;
  // An aborted WRITE still commits on the falling edge, so it is still counted.
  assign step = (state_q == ST_WRITE);

  dma_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .copy_i     (mode == MODE_COPY),
    .src_base_i (src_addr),
    .dst_base_i (dst_addr),
    .len_i      (len),
    .src_ptr_o  (src_ptr),
    .dst_ptr_o  (dst_ptr),
    .remaining_o(remaining),
    .last_o     (last)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          fill_d = fill_val;
          if (len == '0) begin
            state_d = ST_DONE;
          end else if (mode == MODE_FILL) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          buf_d   = mem_rdata;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_FILL) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

  // Memory strobes decode only from registered state, never from inputs.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_READ: begin
        mem_rd   = 1'b1;
        mem_addr = src_ptr;
      end
      ST_WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_ptr;
        mem_wdata = (mode_q == MODE_FILL) ? fill_q : buf_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized self-checking bench for mem_copy_dma against a whole-block
// memmove/fill reference model of the data memory.
module tb_mem_copy_dma;
  import mem_dma_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] src_addr = 8'h00;
  logic [7:0] dst_addr = 8'h00;
  logic [7:0] len = 8'h00;
  logic [7:0] fill_val = 8'h00;
  logic       busy, done, mem_rd, mem_wr;
  logic [7:0] remaining, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] wr_log [4096];
  int         wr_total = 0;
  int         rd_total = 0;
  int         ovl_total = 0;
  logic       ld_we = 1'b0;
  logic [7:0] ld_a = 8'h00;
  logic [7:0] ld_d = 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .abort(abort), .busy(busy), .done(done), .remaining(remaining),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

  // Memory commits writes on the falling edge; also tallies bus activity.
  always @(negedge clk) begin
    if (mem_rd && mem_wr) ovl_total <= ovl_total + 1;
    if (mem_rd) rd_total <= rd_total + 1;
    if (mem_wr) begin
      mem[mem_addr]          <= mem_wdata;
      wr_log[wr_total % 4096] <= mem_addr;
      wr_total               <= wr_total + 1;
    end else if (ld_we) begin
      mem[ld_a] <= ld_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    #1 ld_we = 1'b0;
  endtask

  task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] tmp [256];
    for (int i = 0; i < n; i++) tmp[i] = ref_mem[8'(int'(s) + i)];
    for (int i = 0; i < n; i++) ref_mem[8'(int'(d) + i)] = tmp[i];
  endtask

  task automatic ref_fill(input logic [7:0] d, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) ref_mem[8'(int'(d) + i)] = v;
  endtask

  task automatic mem_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_remaining"}, 32'(remaining), 32'd0);
  endtask

  // Issue one transfer; optionally re-pulse start or pulse abort at a given
  // cycle count after the start edge. Returns cycles to done and bus counts.
  task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] n, input logic [7:0] f,
                     input int poke_at, input int abort_at,
                     output int cyc, output int nwr, output int nrd,
                     output logic [7:0] first_wr);
    int wr0, rd0;
    @(posedge clk);
    #1;
    wr0 = wr_total; rd0 = rd_total;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_val = f;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && busy && cyc < 600) begin
      if (cyc == poke_at) begin
        start = 1'b1; mode = ~m; src_addr = 8'h00; dst_addr = 8'h80; len = 8'd50;
      end
      if (cyc == abort_at) begin
        chk("abort_during_write", 32'(mem_wr), 32'd1);
        abort = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0;
      cyc++;
    end
    if (abort_at < 0) begin
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_remaining", 32'(remaining), 32'd0);
      @(posedge clk);
      #1;
      chk("done_pulse_width", 32'(done), 32'd0);
      chk("idle_after_done", 32'(busy), 32'd0);
    end
    nwr = wr_total - wr0;
    nrd = rd_total - rd0;
    first_wr = wr_log[wr0 % 4096];
  endtask

  initial begin
    int cyc, nwr, nrd;
    logic [7:0] fw, s, d, n, f, keep;
    logic m;
    int seen_done;

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(255)));

    // Forward copy
    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    run(MODE_COPY, 8'h10, 8'h40, 8'd4, 8'h00, -1, -1, cyc, nwr, nrd, fw);
    ref_copy(8'h10, 8'h40, 4);
    $display("xfer fwd_copy: cycles=%0d writes=%0d reads=%0d", cyc, nwr, nrd);
    chk("fwd_cycles", 32'(cyc), 32'd8);
    chk("fwd_writes", 32'(nwr), 32'd4);
    chk("fwd_reads", 32'(nrd), 32'd4);
    chk("fwd_first_wr", 32'(fw), 32'h40);
    chk("fwd_byte43", 32'(mem[8'h43]), 32'hD4);
    mem_cmp("fwd_mem");

    // Overlapping copy must run top-down
    for (int i = 0; i < 5; i++) poke(8'(8'h20 + i), 8'(i + 1));
    run(MODE_COPY, 8'h20, 8'h22, 8'd5, 8'h00, -1, -1, cyc, nwr, nrd, fw);
    ref_copy(8'h20, 8'h22, 5);
    $display("xfer bwd_copy: cycles=%0d writes=%0d first_wr=%02h", cyc, nwr, fw);
    chk("bwd_cycles", 32'(cyc), 32'd10);
    chk("bwd_first_wr", 32'(fw), 32'h26);
    chk("bwd_byte22", 32'(mem[8'h22]), 32'h01);
    chk("bwd_byte26", 32'(mem[8'h26]), 32'h05);
    mem_cmp("bwd_mem");

    // Fill wrapping past the top of memory
    keep = ref_mem[8'h02];
    run(MODE_FILL, 8'h00, 8'hFE, 8'd4, 8'h5A, -1, -1, cyc, nwr, nrd, fw);
    ref_fill(8'hFE, 4, 8'h5A);
    $display("xfer wrap_fill: cycles=%0d writes=%0d reads=%0d", cyc, nwr, nrd);
    chk("fill_cycles", 32'(cyc), 32'd4);
    chk("fill_reads", 32'(nrd), 32'd0);
    chk("fill_byte01", 32'(mem[8'h01]), 32'h5A);
    chk("fill_byte02_kept", 32'(mem[8'h02]), 32'(keep));
    mem_cmp("fill_mem");

    // Zero-length copy
    run(MODE_COPY, 8'h10, 8'h60, 8'd0, 8'h00, -1, -1, cyc, nwr, nrd, fw);
    $display("xfer len0: cycles=%0d writes=%0d reads=%0d", cyc, nwr, nrd);
    chk("len0_cycles", 32'(cyc), 32'd0);
    chk("len0_writes", 32'(nwr), 32'd0);
    chk("len0_reads", 32'(nrd), 32'd0);

    // Second start while busy is ignored
    run(MODE_COPY, 8'h30, 8'h90, 8'd3, 8'h00, 1, -1, cyc, nwr, nrd, fw);
    ref_copy(8'h30, 8'h90, 3);
    $display("xfer start_while_busy: cycles=%0d writes=%0d", cyc, nwr);
    chk("busy_start_writes", 32'(nwr), 32'd3);
    chk("busy_start_cycles", 32'(cyc), 32'd6);
    mem_cmp("busy_start_mem");

    // Abort in the second WRITE of a 4-byte copy
    run(MODE_COPY, 8'h50, 8'hA0, 8'd4, 8'h00, -1, 3, cyc, nwr, nrd, fw);
    ref_copy(8'h50, 8'hA0, 2);
    $display("xfer abort: cycles=%0d writes=%0d remaining=%0d", cyc, nwr, remaining);
    chk("abort_writes", 32'(nwr), 32'd2);
    chk("abort_remaining", 32'(remaining), 32'd2);
    chk("abort_idle", 32'(busy), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_remaining_held", 32'(remaining), 32'd2);
    mem_cmp("abort_mem");

    // Asynchronous reset while in READ
    @(posedge clk);
    #1;
    start = 1'b1; mode = MODE_COPY; src_addr = 8'h10; dst_addr = 8'hC0; len = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    chk("pre_reset_rd", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("xfer reset_mid_read: busy=%0d rd=%0d addr=%02h", busy, mem_rd, mem_addr);
    check_reset_outputs("midreset");
    #3 rst_n = 1'b1;
    mem_cmp("midreset_mem");

    // Randomized transfers
    for (int t = 0; t < 25; t++) begin
      m = 1'($urandom_range(1));
      s = 8'($urandom_range(255));
      d = ($urandom_range(3) == 0) ? 8'(s + 8'($urandom_range(8))) : 8'($urandom_range(255));
      n = 8'($urandom_range(128));
      f = 8'($urandom_range(255));
      run(m, s, d, n, f, -1, -1, cyc, nwr, nrd, fw);
      if (m == MODE_FILL) ref_fill(d, int'(n), f);
      else ref_copy(s, d, int'(n));
      $display("xfer rand%0d: mode=%0d src=%02h dst=%02h len=%0d cycles=%0d writes=%0d",
               t, m, s, d, n, cyc, nwr);
      chk("rand_cycles", 32'(cyc),
          32'((n == 0) ? 0 : ((m == MODE_COPY) ? 2 * int'(n) : int'(n))));
      chk("rand_writes", 32'(nwr), 32'(n));
      chk("rand_reads", 32'(nrd), 32'((m == MODE_COPY) ? int'(n) : 0));
      mem_cmp("rand_mem");
    end

    chk("rd_wr_overlap", 32'(ovl_total), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Bus initiator that drives the 256x8 data memory's rd/wr/addr/data port to move blocks without CPU involvement.
- Copy mode has memmove semantics: overlap-safe via descending order when needed. Fill mode writes a constant.
- Sits beside the CPU and is arbitrated onto the data-memory port while busy.
- Memory contract: write commits on negedge clk when wr=1; read data is combinational from addr while rd=1.

Parameters:
- ADDR_W, 8, memory address width; also the width of len and of the pointers.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = COPY, 1 = FILL; latched at start.
- src_addr  input  ADDR_W  copy source base; latched at start.
- dst_addr  input  ADDR_W  destination base; latched at start.
- len  input  ADDR_W  byte count 0..255; latched at start.
- fill_val  input  DATA_W  FILL constant; latched at start.
- abort  input  1  cancel the current transfer.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on normal completion.
- remaining  output  ADDR_W  bytes not yet written.
- mem_addr  output  ADDR_W  memory address.
- mem_rd  output  1  memory read enable.
- mem_wr  output  1  memory write enable.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all pointers, the data buffer and remaining = 0.
  - busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- States: IDLE, READ, WRITE, DONE. Memory outputs decode from the registered state and pointers; no combinational path from inputs to mem_*.
- IDLE: mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0. On posedge with start=1, latch mode/src/dst/len/fill_val, then:
  - len=0: go to DONE (no memory access).
  - COPY: go to READ.
  - FILL: go to WRITE.
- Direction (COPY only), computed at start:
  - backward when dst≠src and ((dst−src) mod 256) < len; otherwise forward.
  - Forward: pointers start at src and dst, increment by 1.
  - Backward: pointers start at src+len−1 and dst+len−1, decrement by 1.
  - All pointer arithmetic is mod 2^ADDR_W; wrap 0xFF↔0x00 is legal.
- READ: mem_rd=1, mem_addr=src_ptr. At the posedge, capture mem_rdata into buf and go to WRITE.
- WRITE: mem_wr=1, mem_addr=dst_ptr, mem_wdata = buf (COPY) or fill_val (FILL). At the posedge:
  - remaining decrements and pointers step.
  - If remaining reaches 0, go to DONE.
  - Otherwise go to READ (COPY) or stay in WRITE (FILL).
- DONE: done=1 and busy=1 for exactly one cycle, no memory access, then IDLE.
- Latency from the start-sampling edge to the done pulse:
  - COPY: 2·len cycles of access, then DONE.
  - FILL: len cycles, then DONE.
  - len=0: DONE on the next cycle.
- mem_rd and mem_wr are never high in the same cycle.
- start while busy is ignored; inputs are not re-latched.
- abort:
  - Sampled at posedge in READ or WRITE → IDLE next cycle with no done pulse. remaining holds its value until the next start.
  - A WRITE cycle in which abort is asserted still commits, because the memory writes on negedge.
  - abort in IDLE or DONE has no effect.
  - abort together with start in IDLE: start wins.
- Async reset mid-transfer: immediate IDLE, mem_wr drops at once, no done pulse.

Decomposition:
- Shared package / header (mem_dma_pkg): state encoding (IDLE=0, READ=1, WRITE=2, DONE=3) and the MODE_COPY=0 / MODE_FILL=1 constants.
- One natural sub-module: dma_addr_gen. It holds the src/dst pointers and the remaining counter, with load / step / direction inputs. The FSM stays in mem_copy_dma.

Test Plan:
- Forward copy: memory model preloaded at 0x10..0x13 = A1,B2,C3,D4; COPY src=0x10 dst=0x40 len=4 → 0x40..0x43 = A1,B2,C3,D4; done exactly 8 cycles after the start edge plus the DONE cycle; rd/wr never overlap.
- Overlap backward: 0x20..0x24 = 1,2,3,4,5; COPY src=0x20 dst=0x22 len=5 → 0x22..0x26 = 1,2,3,4,5; the first write goes to 0x26.
- Wrap-around fill: FILL dst=0xFE len=4 fill_val=0x5A → 0xFE, 0xFF, 0x00, 0x01 = 0x5A; done 4 cycles after start; 0x02 unchanged.
- len=0 and start-while-busy:
  - COPY len=0 → done on the next cycle, no mem_rd/mem_wr.
  - A second start during a len=3 copy → ignored; exactly 3 writes occur.
- Abort:
  - abort in the second WRITE of a len=4 copy → 2 bytes written, remaining=2, no done, IDLE.
  - rst_n=0 mid-READ → all outputs 0 immediately.
